gx4000_cart_hdr_tx: RTL

Emits a GX4000 cartridge image as a byte stream: a 32-byte RIFF/AMS! header built from its field inputs, then the payload bytes read from cartridge memory. It is the write-side counterpart of the cartridge header parser and uses the same byte layout. It sits between the cartridge RAM and the HPS file-save (upload) channel. The header checksum covers the payload, so the block reads the payload twice: once to compute the checksum, once to stream it.

---
 rtl/gx4000_cart_hdr_tx.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/gx4000_cart_hdr_tx.sv
// gx4000_cart_hdr_tx
// Streams a GX4000 cartridge image: a 32-byte RIFF/AMS! header assembled
// from latched field inputs, followed by the payload read from cartridge
// memory. The header carries a checksum of the payload, so the payload is
// read twice: once to sum it (CSUM), once to stream it (PAY).
//
// Ports:
//   clk_sys, reset_n       clock, asynchronous active-low reset
//   start, abort           begin (IDLE only) / cancel transfer
//   rom_type..rom_title    header fields, latched on accepted start
//   mem_rd, mem_addr       payload read request; mem_data returns 1 cycle later
//   out_valid/out_ready    byte stream handshake; out_data at file offset out_addr
//   busy, done, checksum   status; done pulses once after the last byte
//
// Handshake: a byte transfers on a cycle where out_valid && out_ready are
// both high at the rising clock edge. Once out_valid is raised it stays high,
// and out_data/out_addr stay constant, until that transfer happens (or abort
// / reset cancels the transfer). out_valid does not depend on out_ready.
module gx4000_cart_hdr_tx #(
    parameter int          ADDR_W   = 16,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rom_type,
    input  logic [15:0]       rom_size,
    input  logic [7:0]        rom_version,
    input  logic [31:0]       rom_date,
    input  logic [63:0]       rom_title,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [24:0]       out_addr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HDR,
        S_PAY_RD,   // issue payload read
        S_PAY_LD,   // register returned byte
        S_PAY_TX,   // present byte until accepted
        S_DONE
    } state_t;

    // Largest payload addressable with ADDR_W address bits.
    localparam logic [31:0] MAX_SIZE = (ADDR_W >= 16) ? 32'h0000_FFFF
                                                      : ((32'd1 << ADDR_W) - 32'd1);

    state_t      state, state_nx;
    logic [15:0] idx;
    logic [15:0] acc;
    logic        rd_pend;
    logic [7:0]  data_q;
    logic [15:0] csum_q;
    logic [7:0]  lat_type;
    logic [15:0] lat_size;
    logic [7:0]  lat_version;
    logic [31:0] lat_date;
    logic [63:0] lat_title;
    logic [15:0] cap_size;
    logic [31:0] total_len;
    logic [7:0]  hdr_byte;
    logic        go;

    assign cap_size  = ({16'd0, rom_size} > MAX_SIZE) ? MAX_SIZE[15:0] : rom_size;
    assign total_len = 32'd32 + {16'd0, lat_size};
    assign go        = start && !abort;
    assign busy      = (state != S_IDLE);
    assign checksum  = csum_q;

    // Header byte for the current header index.
    always_comb begin
        hdr_byte = PAD_BYTE;
        case (idx[4:0])
            5'd0:  hdr_byte = 8'h52;
            5'd1:  hdr_byte = 8'h49;
            5'd2:  hdr_byte = 8'h46;
            5'd3:  hdr_byte = 8'h46;
            5'd4:  hdr_byte = total_len[7:0];
            5'd5:  hdr_byte = total_len[15:8];
            5'd6:  hdr_byte = total_len[23:16];
            5'd7:  hdr_byte = total_len[31:24];
            5'd8:  hdr_byte = 8'h41;
            5'd9:  hdr_byte = 8'h4D;
            5'd10: hdr_byte = 8'h53;
            5'd11: hdr_byte = 8'h21;
            5'd12: hdr_byte = lat_type;
            5'd13: hdr_byte = lat_size[7:0];
            5'd14: hdr_byte = lat_size[15:8];
            5'd15: hdr_byte = csum_q[7:0];
            5'd16: hdr_byte = csum_q[15:8];
            5'd17: hdr_byte = lat_version;
            5'd18: hdr_byte = lat_date[7:0];
            5'd19: hdr_byte = lat_date[15:8];
            5'd20: hdr_byte = lat_date[23:16];
            5'd21: hdr_byte = lat_date[31:24];
            5'd22: hdr_byte = lat_title[7:0];
            5'd23: hdr_byte = lat_title[15:8];
            5'd24: hdr_byte = lat_title[23:16];
            5'd25: hdr_byte = lat_title[31:24];
            5'd26: hdr_byte = lat_title[39:32];
            5'd27: hdr_byte = lat_title[47:40];
            5'd28: hdr_byte = lat_title[55:48];
            5'd29: hdr_byte = lat_title[63:56];
            default: hdr_byte = PAD_BYTE;
        endcase
    end

    // Next state and outputs.
    always_comb begin
        state_nx  = state;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_addr  = 25'd0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nx = (cap_size != 16'd0) ? S_CSUM : S_HDR;
            end
            S_CSUM: begin
                if (idx < lat_size) begin
                    mem_rd   = 1'b1;
                    mem_addr = ADDR_W'(idx);
                end else begin
                    state_nx = S_HDR;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_byte;
                out_addr  = {20'd0, idx[4:0]};
                if (out_ready && idx[4:0] == 5'd31)
                    state_nx = (lat_size != 16'd0) ? S_PAY_RD : S_DONE;
            end
            S_PAY_RD: begin
                mem_rd   = 1'b1;
                mem_addr = ADDR_W'(idx);
                state_nx = S_PAY_LD;
            end
            S_PAY_LD: begin
                state_nx = S_PAY_TX;
            end
            S_PAY_TX: begin
                out_valid = 1'b1;
                out_data  = data_q;
                out_addr  = 25'd32 + {9'd0, idx};
                if (out_ready)
                    state_nx = (idx == lat_size - 16'd1) ? S_DONE : S_PAY_RD;
            end
            S_DONE: begin
                // An abort arriving on the done cycle cancels the pulse.
                done     = !abort;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nx = S_IDLE;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: counters, accumulator, latched fields.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= 16'd0;
            acc         <= 16'd0;
            rd_pend     <= 1'b0;
            data_q      <= 8'h00;
            csum_q      <= 16'd0;
            lat_type    <= 8'h00;
            lat_size    <= 16'd0;
            lat_version <= 8'h00;
            lat_date    <= 32'd0;
            lat_title   <= 64'd0;
        end else if (state == S_IDLE) begin
            if (go) begin
                lat_type    <= rom_type;
                lat_size    <= cap_size;
                lat_version <= rom_version;
                lat_date    <= rom_date;
                lat_title   <= rom_title;
                idx         <= 16'd0;
                acc         <= 16'd0;
                rd_pend     <= 1'b0;
                if (cap_size == 16'd0) csum_q <= 16'd0;
            end
        end else if (!abort) begin
            case (state)
                S_CSUM: begin
                    // Data for the read issued last cycle arrives now.
                    rd_pend <= (idx < lat_size);
                    if (rd_pend) acc <= acc + {8'd0, mem_data};
                    if (idx < lat_size) begin
                        idx <= idx + 16'd1;
                    end else begin
                        csum_q <= acc + (rd_pend ? {8'd0, mem_data} : 16'd0);
                        idx    <= 16'd0;
                    end
                end
                S_HDR: begin
                    if (out_ready) idx <= (idx[4:0] == 5'd31) ? 16'd0 : idx + 16'd1;
                end
                S_PAY_LD: begin
                    data_q <= mem_data;
                end
                S_PAY_TX: begin
                    if (out_ready) idx <= idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
